reservation_station: RTL
========================

# reservation_station

Holds dispatched ALU operations until their source operands are available, then issues each ready entry to a free functional unit. It sits between rename/dispatch and the bank of functional units. It is the issuing end of the FU issue interface (write_enable / is_available) and a consumer of the FU wakeup buses, which it snoops to resolve pending operand tags.

## Interface
Parameters:
- ENTRIES, 16, number of station slots (power of two, ≥2)
- NUM_FU, 3, number of functional units driven
- NUM_WAKEUP, 3, number of wakeup buses snooped

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous clear of all entries
- dispatch_valid  in  1  new operation presented
- dispatch_ready  out  1  at least one free slot
- d_ALUControl  in  4  operation code
- d_ALUSrc  in  1  0 = rs1 op rs2, 1 = rs1 op imm
- d_is_for_lsq  in  1  result goes to the LSQ address bus
- d_imm  in  32  immediate
- d_rs1_ready, d_rs2_ready  in  1 each  operand value already valid
- d_rs1_tag, d_rs2_tag  in  6 each  producer tag when not ready
- d_rs1_value, d_rs2_value  in  32 each  operand value when ready
- d_dest_tag  in  6  tag to broadcast on completion
- d_rob_index  in  6  ROB slot
- wk_active  in  NUM_WAKEUP  per-bus valid
- wk_tag  in  6*NUM_WAKEUP  bus i at bits [6i+5:6i]
- wk_value  in  32*NUM_WAKEUP  bus i at bits [32i+31:32i]
- fu_is_available  in  NUM_FU  per-FU free indication (combinational from FU)
- fu_write_enable  out  NUM_FU  issue strobe, sampled by FU at posedge
- fu_ALUControl  out  4*NUM_FU
- fu_ALUSrc, fu_is_for_lsq  out  NUM_FU each
- fu_imm, fu_rs1_value, fu_rs2_value  out  32*NUM_FU each
- fu_tag_to_output, fu_rob_index  out  6*NUM_FU each
- occupancy  out  $clog2(ENTRIES)+1  count of valid entries

## Operation
- Per entry state: valid, the opcode fields, and for each operand a ready bit, a tag and a 32-bit value.
- Dispatch:
  - On a posedge with dispatch_valid && dispatch_ready, the lowest-index free slot is written.
  - dispatch_valid while !dispatch_ready is ignored, and simulation raises $fatal.
- Wakeup capture:
  - Every posedge, for each valid entry and each non-ready operand: if wk_active[i] and wk_tag[i] == operand tag, latch wk_value[i] and set ready.
  - If several buses match, the lowest i wins.
  - Wakeup also applies to an operation being dispatched in the same cycle. A non-ready d_rs tag matching an active bus is written as ready with the bus value.
- Operand 2 is considered ready regardless of its ready bit when ALUSrc = 1.
- Issue select, combinational, each cycle:
  - An entry is eligible when it is valid and both operands are ready.
  - FUs are served in ascending index. FU k receives the lowest-index eligible entry not already taken by a lower FU, provided fu_is_available[k] is high.
  - fu_write_enable[k] is asserted for exactly that cycle with the entry fields. The entry is freed at that posedge.
- An entry is never issued to two FUs, and never issued twice.
- Non-issuing FU output fields are don't-care. They are driven from entry 0 to avoid X.
- dispatch_ready = (occupancy < ENTRIES), computed from current state only. A slot freed by issue in cycle N is dispatchable from cycle N+1.
- flush: at the posedge, all entries are invalidated and any same-cycle dispatch is dropped. fu_write_enable is forced to 0 during a flush cycle.

## Timing
- Reset values:
  - all entries invalid, occupancy 0, dispatch_ready 1
  - fu_write_enable all 0
  - fu data outputs 0, except fu_rob_index which resets to 6'h3F
- Dispatch of a fully ready operation at posedge E: earliest fu_write_enable is in the cycle following E (issue latency 1).
- Operand woken by a bus active in cycle W: the value is latched at the end of W, and the earliest issue is in W+1 (without the bypass macro).
- A reset asserted mid-operation clears everything immediately. No partial issue survives.

## Configuration
- RS_WAKEUP_BYPASS_EN defined:
  - An entry whose only missing operands are matched by active buses in cycle W is eligible in W itself.
  - fu_rs*_value is forwarded combinationally from wk_value.
  - Wakeup-to-issue latency becomes 0.
- RS_WAKEUP_BYPASS_EN undefined: eligibility uses registered ready bits only, and the latency is 1.

## Test plan
- Reset, then dispatch ADD (rs1 = 5, rs2 = 7, both ready, dest 12, rob 3) with FU0 available → fu_write_enable[0] = 1 the next cycle, carrying rs1 = 5, rs2 = 7, tag 12, rob 3; occupancy returns to 0.
- Dispatch XOR with rs1 waiting on tag 9, then drive wk_active[1] = 1, tag 9, value 0xA5 in cycle W → issue carries rs1 = 0xA5 in W+1 (in W with RS_WAKEUP_BYPASS_EN).
- Fill all 16 slots with ops waiting on tag 20 → dispatch_ready = 0; an extra dispatch_valid raises $fatal; a broadcast of tag 20 with 3 FUs available → entries 0, 1, 2 issue to FU0, FU1, FU2.
- Dispatch in the same cycle that tag 4 is broadcast, with d_rs2_tag = 4 and d_rs2_ready = 0 → the entry stores the value and issues the next cycle without a further wakeup.
- Three ready entries, fu_is_available = 3'b010 → only FU1 gets entry 0; the rest issue in later cycles.
- Assert flush with 5 valid entries and a dispatch pending → next cycle occupancy = 0, no fu_write_enable observed.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station: holds ALU ops until operands resolve, issues to FUs.
// Optional RS_WAKEUP_BYPASS_EN: issue in the same cycle as the waking bus.
module reservation_station #(
  parameter int ENTRIES    = 16,
  parameter int NUM_FU     = 3,
  parameter int NUM_WAKEUP = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  logic [3:0]               d_ALUControl,
  input  logic                     d_ALUSrc,
  input  logic                     d_is_for_lsq,
  input  logic [31:0]              d_imm,
  input  logic                     d_rs1_ready,
  input  logic                     d_rs2_ready,
  input  logic [5:0]               d_rs1_tag,
  input  logic [5:0]               d_rs2_tag,
  input  logic [31:0]              d_rs1_value,
  input  logic [31:0]              d_rs2_value,
  input  logic [5:0]               d_dest_tag,
  input  logic [5:0]               d_rob_index,
  input  logic [NUM_WAKEUP-1:0]    wk_active,
  input  logic [6*NUM_WAKEUP-1:0]  wk_tag,
  input  logic [32*NUM_WAKEUP-1:0] wk_value,
  input  logic [NUM_FU-1:0]        fu_is_available,
  output logic [NUM_FU-1:0]        fu_write_enable,
  output logic [4*NUM_FU-1:0]      fu_ALUControl,
  output logic [NUM_FU-1:0]        fu_ALUSrc,
  output logic [NUM_FU-1:0]        fu_is_for_lsq,
  output logic [32*NUM_FU-1:0]     fu_imm,
  output logic [32*NUM_FU-1:0]     fu_rs1_value,
  output logic [32*NUM_FU-1:0]     fu_rs2_value,
  output logic [6*NUM_FU-1:0]      fu_tag_to_output,
  output logic [6*NUM_FU-1:0]      fu_rob_index,
  output logic [$clog2(ENTRIES):0] occupancy
);
  localparam int IW = $clog2(ENTRIES);

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic        is_for_lsq;
    logic [31:0] imm;
    logic        rs1_ready;
    logic [5:0]  rs1_tag;
    logic [31:0] rs1_value;
    logic        rs2_ready;
    logic [5:0]  rs2_tag;
    logic [31:0] rs2_value;
    logic [5:0]  dest_tag;
    logic [5:0]  rob_index;
  } entry_t;

  entry_t             ent [ENTRIES];
  entry_t             new_ent;
  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] valid_nxt;
  logic [ENTRIES-1:0] elig;
  logic [ENTRIES-1:0] taken;
  logic [ENTRIES-1:0] hit1;
  logic [ENTRIES-1:0] hit2;
  logic [31:0]        wv1 [ENTRIES];
  logic [31:0]        wv2 [ENTRIES];
  logic [31:0]        op1 [ENTRIES];
  logic [31:0]        op2 [ENTRIES];
  logic [IW-1:0]      sel [NUM_FU];
  logic [IW-1:0]      free_idx;
  logic               dispatch_fire;
  logic               dh1;
  logic               dh2;
  logic [31:0]        dv1;
  logic [31:0]        dv2;

  // lowest-index active bus with a matching tag wins
  function automatic logic [32:0] snoop(input logic [5:0] tag);
    logic [32:0] r;
    r = '0;
    for (int i = NUM_WAKEUP - 1; i >= 0; i--)
      if (wk_active[i] && wk_tag[6*i +: 6] == tag)
        r = {1'b1, wk_value[32*i +: 32]};
    return r;
  endfunction

  always_comb begin
    logic rdy1;
    logic rdy2;
    for (int e = 0; e < ENTRIES; e++) begin
      {hit1[e], wv1[e]} = snoop(ent[e].rs1_tag);
      {hit2[e], wv2[e]} = snoop(ent[e].rs2_tag);
`ifdef RS_WAKEUP_BYPASS_EN
      rdy1 = ent[e].rs1_ready | hit1[e];
      rdy2 = ent[e].rs2_ready | hit2[e];
      op1[e] = ent[e].rs1_ready ? ent[e].rs1_value : wv1[e];
      op2[e] = ent[e].rs2_ready ? ent[e].rs2_value : wv2[e];
`else
      rdy1 = ent[e].rs1_ready;
      rdy2 = ent[e].rs2_ready;
      op1[e] = ent[e].rs1_value;
      op2[e] = ent[e].rs2_value;
`endif
      elig[e] = valid[e] & rdy1 & (rdy2 | ent[e].alu_src);
    end
  end

  always_comb begin
    logic found;
    taken = '0;
    fu_write_enable = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sel[k] = '0;
      found = 1'b0;
      if (fu_is_available[k] && !flush) begin
        for (int e = 0; e < ENTRIES; e++) begin
          if (!found && elig[e] && !taken[e]) begin
            found = 1'b1;
            sel[k] = IW'(e);
          end
        end
      end
      if (found)
        taken[sel[k]] = 1'b1;
      fu_write_enable[k] = found;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      fu_ALUControl[4*k +: 4]     = ent[sel[k]].alu_ctrl;
      fu_ALUSrc[k]                = ent[sel[k]].alu_src;
      fu_is_for_lsq[k]            = ent[sel[k]].is_for_lsq;
      fu_imm[32*k +: 32]          = ent[sel[k]].imm;
      fu_rs1_value[32*k +: 32]    = op1[sel[k]];
      fu_rs2_value[32*k +: 32]    = op2[sel[k]];
      fu_tag_to_output[6*k +: 6]  = ent[sel[k]].dest_tag;
      fu_rob_index[6*k +: 6]      = ent[sel[k]].rob_index;
    end
  end

  always_comb begin
    occupancy = '0;
    free_idx = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      occupancy = occupancy + {{IW{1'b0}}, valid[e]};
      if (!valid[e])
        free_idx = IW'(e);
    end
  end

  assign dispatch_ready = ~&valid;
  assign dispatch_fire  = dispatch_valid & dispatch_ready & ~flush;

  always_comb begin
    {dh1, dv1} = snoop(d_rs1_tag);
    {dh2, dv2} = snoop(d_rs2_tag);
    new_ent.alu_ctrl   = d_ALUControl;
    new_ent.alu_src    = d_ALUSrc;
    new_ent.is_for_lsq = d_is_for_lsq;
    new_ent.imm        = d_imm;
    new_ent.rs1_ready  = d_rs1_ready | dh1;
    new_ent.rs1_tag    = d_rs1_tag;
    new_ent.rs1_value  = (!d_rs1_ready && dh1) ? dv1 : d_rs1_value;
    new_ent.rs2_ready  = d_rs2_ready | dh2;
    new_ent.rs2_tag    = d_rs2_tag;
    new_ent.rs2_value  = (!d_rs2_ready && dh2) ? dv2 : d_rs2_value;
    new_ent.dest_tag   = d_dest_tag;
    new_ent.rob_index  = d_rob_index;
  end

  always_comb begin
    valid_nxt = valid & ~taken;
    if (dispatch_fire)
      valid_nxt[free_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        ent[e] <= '0;
        ent[e].rob_index <= 6'h3F;
      end
    end else if (flush) begin
      valid <= '0;
    end else begin
      valid <= valid_nxt;
      for (int e = 0; e < ENTRIES; e++) begin
        if (valid[e] && !ent[e].rs1_ready && hit1[e]) begin
          ent[e].rs1_ready <= 1'b1;
          ent[e].rs1_value <= wv1[e];
        end
        if (valid[e] && !ent[e].rs2_ready && hit2[e]) begin
          ent[e].rs2_ready <= 1'b1;
          ent[e].rs2_value <= wv2[e];
        end
        if (dispatch_fire && free_idx == IW'(e))
          ent[e] <= new_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && dispatch_valid && !dispatch_ready)
      $fatal(1, "reservation_station: dispatch while full");
  end

endmodule
